// File: rtl/branch_predict_fetch_pkg.sv
// Shared types for the fetch-stage branch predictor.
// Counter encodings, default sizes and the saturating step.
package branch_predict_fetch_pkg;

  localparam int DEF_ENTRIES = 16;
  localparam int DEF_PC_W    = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  function automatic cnt_e cnt_next(
    input cnt_e c,
    input logic taken
  );
    cnt_e r;
    r = c;
    unique case (1'b1)
      (taken && c != ST):   r = cnt_e'(c + 2'd1);
      (!taken && c != SNT): r = cnt_e'(c - 2'd1);
      default:              r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_fetch_counter_table.sv
// ENTRIES x 2-bit saturating counters.
// One async read port, one registered update port.
module bp_counter_table
  import branch_predict_fetch_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output cnt_e          rd_cnt,
  input  logic          upd_en,
  input  logic [IW-1:0] upd_idx,
  input  logic          upd_taken
);

  cnt_e ctr_q [ENTRIES];
  cnt_e ctr_d [ENTRIES];

  // Read sees the stored value; an update lands next cycle.
  assign rd_cnt = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      ctr_d[upd_idx] = cnt_next(ctr_q[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q <= '{default: WNT};
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch PC generator with 2-bit bimodal prediction
// and EX-stage mispredict redirect.
module branch_predict_fetch
  import branch_predict_fetch_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int PC_W    = DEF_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            memory_stall,
  input  logic            is_branch_1,
  input  logic            is_jal_1,
  input  logic [PC_W-1:0] imm_1,
  input  logic            is_branchInst_3,
  input  logic            taken_3,
  input  logic [PC_W-1:0] target_3,
  input  logic [PC_W-1:0] instructionPC_3,
  input  logic            prev_taken_3,
  output logic [PC_W-1:0] PC_1,
  output logic            pred_taken_1,
  output logic            flush,
  output logic [15:0]     mispredict_cnt
);

  localparam int IW = $clog2(ENTRIES);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  cnt_e            rd_cnt;
  logic            mispredict;
  logic            upd_en;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^{instructionPC_3[PC_W-1:IW+2],
                            instructionPC_3[1:0]};

  bp_counter_table #(
    .ENTRIES (ENTRIES),
    .IW      (IW)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc_q[IW+1:2]),
    .rd_cnt    (rd_cnt),
    .upd_en    (upd_en),
    .upd_idx   (instructionPC_3[IW+1:2]),
    .upd_taken (taken_3)
  );

  assign pred_taken_1 = is_branch_1 &
    (is_jal_1 | rd_cnt == WT | rd_cnt == ST);

  // Stall holds EX, so gating by stall makes one update per branch.
  assign mispredict = is_branchInst_3 & (taken_3 != prev_taken_3);
  assign flush      = mispredict & ~memory_stall;
  assign upd_en     = is_branchInst_3 & ~memory_stall;

  always_comb begin
    pc_d = pc_q + PC_W'(4);
    if (flush) begin
      pc_d = target_3;
    end else if (memory_stall) begin
      pc_d = pc_q;
    end else if (pred_taken_1) begin
      pc_d = pc_q + imm_1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign PC_1           = pc_q;
  assign mispredict_cnt = cnt_q;

endmodule
